// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared constants, types and helpers for the iterative AES
//               key schedule (key-length encoding, Nk/Nr lookup, xtime and
//               the schedule state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // key_len encoding
    localparam logic [1:0] c_KEY_LEN_128  = 2'd0;
    localparam logic [1:0] c_KEY_LEN_192  = 2'd1;
    localparam logic [1:0] c_KEY_LEN_256  = 2'd2;
    localparam logic [1:0] c_KEY_LEN_RSVD = 2'd3;

    // Schedule sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Number of 32-bit words in the cipher key
    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            c_KEY_LEN_192: nk_of = 4'd6;
            c_KEY_LEN_256: nk_of = 4'd8;
            default:       nk_of = 4'd4;
        endcase
    endfunction

    // Number of cipher rounds (Nr + 1 round keys are emitted)
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            c_KEY_LEN_192: nr_of = 4'd12;
            c_KEY_LEN_256: nr_of = 4'd14;
            default:       nr_of = 4'd10;
        endcase
    endfunction

    // Key length in bits; the reserved code maps to 0 and is rejected separately
    function automatic int unsigned key_bits_of(input logic [1:0] key_len);
        case (key_len)
            c_KEY_LEN_128: key_bits_of = 128;
            c_KEY_LEN_192: key_bits_of = 192;
            c_KEY_LEN_256: key_bits_of = 256;
            default:       key_bits_of = 0;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : AES forward S-box, purely combinational table lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Row 0 (entries 0x00..0x0f) sits in the most significant bits
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_idx;

    assign w_idx  = 11'd2047 - {i_byte, 3'b000};
    assign o_byte = c_SBOX[w_idx -: 8];

endmodule
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_sub_word
// Description : SubWord - applies the AES S-box to each byte of a 32-bit
//               word. Shared by the RotWord and the Nk=8 SubWord paths.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sub_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (i_word[8*b +: 8]),
            .o_byte (o_word[8*b +: 8])
        );
    end

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule_seq
// Description : Iterative AES-128/192/256 key schedule. Produces one 32-bit
//               schedule word per cycle through a single SubWord datapath
//               and streams the Nr+1 round keys over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256,
    parameter int unsigned RK_IDX_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [255:0]        key_in,
    input  logic [1:0]          key_len,
    output logic                busy,
    output logic                err,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic [127:0]        rk_data,
    output logic                rk_last
);

    state_t                r_state;
    logic [255:0]          r_key;       // key words, consumed from the top
    logic [3:0]            r_nk;
    logic [3:0]            r_nr;
    logic [5:0]            r_i;         // index of the word produced this cycle
    logic [2:0]            r_j;         // r_i mod Nk, kept incrementally
    logic [7:0]            r_rcon;
    logic [31:0]           r_hist [8];  // r_hist[0] = w[i-1], r_hist[k] = w[i-1-k]
    logic [95:0]           r_acc;
    logic [1:0]            r_acc_cnt;
    logic [RK_IDX_W-1:0]   r_rnd;       // index of the next round key to emit

    logic                  r_busy;
    logic                  r_err;
    logic                  r_rk_valid;
    logic [RK_IDX_W-1:0]   r_rk_idx;
    logic [127:0]          r_rk_data;
    logic                  r_rk_last;

    logic                  w_reject;
    logic                  w_stall;
    logic                  w_gen;
    logic                  w_hs;
    logic                  w_key_phase;
    logic                  w_j_zero;
    logic                  w_nk8_mid;
    logic                  w_last_word;
    logic [2:0]            w_back_sel;
    logic [2:0]            w_j_next;
    logic [31:0]           w_prev;
    logic [31:0]           w_back;
    logic [31:0]           w_sub_in;
    logic [31:0]           w_sub_out;
    logic [31:0]           w_word;

    assign w_reject    = (key_len == c_KEY_LEN_RSVD) || (key_bits_of(key_len) > MAX_KEY_BITS);
    assign w_hs        = r_rk_valid && rk_ready;
    // The 4th word of a key can only leave if the output register is free
    assign w_stall     = (r_acc_cnt == 2'd3) && r_rk_valid && !rk_ready;
    assign w_gen       = (r_state == S_RUN) && !w_stall;
    assign w_key_phase = (6'(r_nk) > r_i);
    assign w_j_zero    = (r_j == 3'd0);
    assign w_nk8_mid   = (r_nk == 4'd8) && (r_j == 3'd4);
    assign w_last_word = (r_i == {r_nr, 2'b11});
    assign w_back_sel  = 3'(r_nk - 4'd1);
    assign w_j_next    = (r_j == w_back_sel) ? 3'd0 : r_j + 3'd1;
    assign w_prev      = r_hist[0];
    assign w_back      = r_hist[w_back_sel];
    // RotWord is only applied on the i mod Nk == 0 path
    assign w_sub_in    = w_j_zero ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // Next schedule word w[i]
    always_comb begin
        w_word = w_back ^ w_prev;
        if (w_key_phase) begin
            w_word = r_key[255:224];
        end else if (w_j_zero) begin
            w_word = w_back ^ w_sub_out ^ {r_rcon, 24'h000000};
        end else if (w_nk8_mid) begin
            w_word = w_back ^ w_sub_out;
        end
    end

    // Sequencer, word generation, round-key assembly and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_key      <= '0;
            r_nk       <= 4'd4;
            r_nr       <= 4'd10;
            r_i        <= '0;
            r_j        <= '0;
            r_rcon     <= 8'h01;
            r_acc      <= '0;
            r_acc_cnt  <= '0;
            r_rnd      <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk_idx   <= '0;
            r_rk_data  <= '0;
            r_rk_last  <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_hist[k] <= '0;
            end
        end else begin
            r_err <= 1'b0;
            // Accepted key leaves unless a new one is transferred below
            if (w_hs) begin
                r_rk_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_key     <= key_in;
                            r_nk      <= nk_of(key_len);
                            r_nr      <= nr_of(key_len);
                            r_i       <= '0;
                            r_j       <= '0;
                            r_rcon    <= 8'h01;
                            r_acc_cnt <= '0;
                            r_rnd     <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_gen) begin
                        r_key     <= {r_key[223:0], 32'h00000000};
                        r_hist[0] <= w_word;
                        for (int k = 1; k < 8; k++) begin
                            r_hist[k] <= r_hist[k-1];
                        end
                        r_i <= r_i + 6'd1;
                        r_j <= w_j_next;
                        if (!w_key_phase && w_j_zero) begin
                            r_rcon <= xtime(r_rcon);
                        end
                        if (r_acc_cnt == 2'd3) begin
                            r_rk_valid <= 1'b1;
                            r_rk_data  <= {r_acc, w_word};
                            r_rk_idx   <= r_rnd;
                            r_rk_last  <= (r_rnd == RK_IDX_W'(r_nr));
                            r_rnd      <= r_rnd + 1'b1;
                            r_acc_cnt  <= 2'd0;
                        end else begin
                            r_acc     <= {r_acc[63:0], w_word};
                            r_acc_cnt <= r_acc_cnt + 2'd1;
                        end
                        if (w_last_word) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_hs && r_rk_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign err      = r_err;
    assign rk_valid = r_rk_valid;
    assign rk_idx   = r_rk_idx;
    assign rk_data  = r_rk_data;
    assign rk_last  = r_rk_last;

endmodule
`default_nettype wire
